// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: memory-mapped I/O bus controller between the CPU data port and
// NSLV peripheral slots. It decodes the region field of the address, runs one
// request/ready handshake at a time, and returns registered read data with an ack pulse.
// Unmapped addresses complete with cpu_err set.
// Optional macro BUS_TIMEOUT_EN adds an ACCESS watchdog that aborts after TIMEOUT_CYC
// cycles without ready.
module mio_bus_ctrl #(
  parameter int unsigned         NSLV        = 4,
  parameter int unsigned         AW          = 32,
  parameter int unsigned         DW          = 32,
  parameter int unsigned         RW          = 4,
  parameter logic [NSLV*RW-1:0]  SLV_REGION  = {4'hf, 4'he, 4'hd, 4'h0},
  parameter int unsigned         TIMEOUT_CYC = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [AW-1:0]      i_cpu_addr,
  input  logic [DW-1:0]      i_cpu_wdata,
  output logic [DW-1:0]      o_cpu_rdata,
  output logic               o_cpu_ack,
  output logic               o_cpu_err,
  output logic               o_cpu_busy,
  output logic [NSLV-1:0]    o_slv_sel,
  output logic               o_slv_we,
  output logic [AW-1:0]      o_slv_addr,
  output logic [DW-1:0]      o_slv_wdata,
  input  logic [NSLV*DW-1:0] i_slv_rdata,
  input  logic [NSLV-1:0]    i_slv_rdy
);

  if (NSLV < 1 || NSLV > 8 || TIMEOUT_CYC < 1) begin : g_param_err
    $error("mio_bus_ctrl: NSLV must be 1..8 and TIMEOUT_CYC at least 1");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

  state_t            r_state, w_state_d;
  logic [DW-1:0]     r_rdata, w_rdata_d;
  logic              r_ack, w_ack_d;
  logic              r_err, w_err_d;
  logic              r_busy, w_busy_d;
  logic [NSLV-1:0]   r_sel, w_sel_d;
  logic              r_we, w_we_d;
  logic [AW-1:0]     r_addr, w_addr_d;
  logic [DW-1:0]     r_wdata, w_wdata_d;
  // Outcome of the transaction, presented on cpu_err during the ack cycle
  logic              r_err_flag, w_err_flag_d;

  logic              w_hit;
  logic [NSLV-1:0]   w_hit_oh;
  logic              w_sel_rdy;
  logic [DW-1:0]     w_sel_rdata;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] r_tmo, w_tmo_d;
`endif

  // Region decode; scanning from the top down lets the lowest matching slot win
  always_comb begin
    w_hit    = 1'b0;
    w_hit_oh = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (i_cpu_addr[AW-1 -: RW] == SLV_REGION[i*RW +: RW]) begin
        w_hit       = 1'b1;
        w_hit_oh    = '0;
        w_hit_oh[i] = 1'b1;
      end
    end
  end

  // Ready and read data of the selected slot only; other slots are masked off
  always_comb begin
    w_sel_rdy   = |(i_slv_rdy & r_sel);
    w_sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_sel[i]) w_sel_rdata = w_sel_rdata | i_slv_rdata[i*DW +: DW];
    end
  end

  // Next-state and next registered-output logic
  always_comb begin
    w_state_d    = r_state;
    w_rdata_d    = r_rdata;
    w_ack_d      = 1'b0;
    w_err_d      = 1'b0;
    w_sel_d      = r_sel;
    w_we_d       = r_we;
    w_addr_d     = r_addr;
    w_wdata_d    = r_wdata;
    w_err_flag_d = r_err_flag;
`ifdef BUS_TIMEOUT_EN
    w_tmo_d      = r_tmo;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_cpu_req) begin
          w_addr_d  = i_cpu_addr;
          w_we_d    = i_cpu_we;
          w_wdata_d = i_cpu_wdata;
          if (w_hit) begin
            w_sel_d      = w_hit_oh;
            w_err_flag_d = 1'b0;
            w_state_d    = StAccess;
`ifdef BUS_TIMEOUT_EN
            w_tmo_d      = TmoW'(TIMEOUT_CYC);
`endif
          end else begin
            w_rdata_d    = '0;
            w_err_flag_d = 1'b1;
            w_state_d    = StResp;
          end
        end
      end
      StAccess: begin
        if (w_sel_rdy) begin
          // Ready wins even when the watchdog expires in the same cycle
          w_rdata_d    = r_we ? '0 : w_sel_rdata;
          w_sel_d      = '0;
          w_we_d       = 1'b0;
          w_err_flag_d = 1'b0;
          w_state_d    = StResp;
        end
`ifdef BUS_TIMEOUT_EN
        else if (r_tmo == '0) begin
          w_rdata_d    = '0;
          w_sel_d      = '0;
          w_we_d       = 1'b0;
          w_err_flag_d = 1'b1;
          w_state_d    = StResp;
        end else begin
          w_tmo_d = r_tmo - 1'b1;
        end
`endif
      end
      StResp: begin
        w_ack_d   = 1'b1;
        w_err_d   = r_err_flag;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d != StIdle);
  end

  // State and output registers; reset abandons any transaction without an ack
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_rdata    <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err_flag <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_rdata    <= w_rdata_d;
      r_ack      <= w_ack_d;
      r_err      <= w_err_d;
      r_busy     <= w_busy_d;
      r_sel      <= w_sel_d;
      r_we       <= w_we_d;
      r_addr     <= w_addr_d;
      r_wdata    <= w_wdata_d;
      r_err_flag <= w_err_flag_d;
`ifdef BUS_TIMEOUT_EN
      r_tmo      <= w_tmo_d;
`endif
    end
  end

  assign o_cpu_rdata = r_rdata;
  assign o_cpu_ack   = r_ack;
  assign o_cpu_err   = r_err;
  assign o_cpu_busy  = r_busy;
  assign o_slv_sel   = r_sel;
  assign o_slv_we    = r_we;
  assign o_slv_addr  = r_addr;
  assign o_slv_wdata = r_wdata;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: table of single transactions plus
// hand-written sequences for reset mid-op, watchdog behaviour and back-to-back issue.
module tb_mio_bus_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_ack, cpu_err, cpu_busy;
  logic [3:0]   slv_sel;
  logic         slv_we;
  logic [31:0]  slv_addr, slv_wdata;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  mio_bus_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ack   (cpu_ack),
    .o_cpu_err   (cpu_err),
    .o_cpu_busy  (cpu_busy),
    .o_slv_sel   (slv_sel),
    .o_slv_we    (slv_we),
    .o_slv_addr  (slv_addr),
    .o_slv_wdata (slv_wdata),
    .i_slv_rdata (slv_rdata),
    .i_slv_rdy   (slv_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] slot_data;  // read data driven by the addressed slot
    int          rdy_dly;    // ACCESS cycles with rdy low before rdy
    logic [3:0]  stray;      // rdy driven on other cycles
    logic [3:0]  exp_sel;
    int          exp_lat;    // clock edges from request to ack
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rdata"}, cpu_rdata, 32'h0);
    check({tag, " ack"}, {31'h0, cpu_ack}, 32'h0);
    check({tag, " err"}, {31'h0, cpu_err}, 32'h0);
    check({tag, " busy"}, {31'h0, cpu_busy}, 32'h0);
    check({tag, " sel"}, {28'h0, slv_sel}, 32'h0);
    check({tag, " we"}, {31'h0, slv_we}, 32'h0);
    check({tag, " addr"}, slv_addr, 32'h0);
    check({tag, " wdata"}, slv_wdata, 32'h0);
  endtask

  // Non-addressed slots return tagged junk so a wrong-slot capture is visible
  task automatic fill_rdata(input logic [3:0] sel, input logic [31:0] d);
    for (int s = 0; s < 4; s++) slv_rdata[s*32 +: 32] = sel[s] ? d : (32'hDEAD_0000 | s);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    logic  held;
    int    lat;
    tag = $sformatf("vec%0d", idx);
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    slv_rdy   = 4'b0;
    fill_rdata(v.exp_sel, v.slot_data);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    check({tag, " sel"}, {28'h0, slv_sel}, {28'h0, v.exp_sel});
    check({tag, " busy"}, {31'h0, cpu_busy}, 32'h1);
    check({tag, " slv_addr"}, slv_addr, v.addr);
    check({tag, " slv_we"}, {31'h0, slv_we}, {31'h0, v.we});
    if (v.we) check({tag, " slv_wdata"}, slv_wdata, v.wdata);
    held = 1'b1;
    lat  = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      slv_rdy = (k == v.rdy_dly + 1) ? v.exp_sel : v.stray;
      @(posedge clk); #1;
      if (k <= v.rdy_dly && (slv_sel != v.exp_sel || slv_we != v.we)) held = 1'b0;
      if (cpu_ack) lat = k;
    end
    slv_rdy = 4'b0;
    check({tag, " sel/we held"}, {31'h0, held}, 32'h1);
    check({tag, " ack latency"}, lat, v.exp_lat);
    check({tag, " rdata"}, cpu_rdata, v.exp_rdata);
    check({tag, " err"}, {31'h0, cpu_err}, {31'h0, v.exp_err});
    check({tag, " sel at ack"}, {28'h0, slv_sel}, 32'h0);
    check({tag, " busy at ack"}, {31'h0, cpu_busy}, 32'h0);
    @(posedge clk); #1;
    check({tag, " ack one cycle"}, {31'h0, cpu_ack}, 32'h0);
    check({tag, " rdata hold"}, cpu_rdata, v.exp_rdata);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 4'b0000, 4'b0001, 2,
                32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 32'hF000_0004, 32'hA5, 32'hFFFF_FFFF, 3, 4'b0000, 4'b1000, 5,
                32'h0, 1'b0};
    vecs[2] = '{1'b0, 32'hE000_0008, 32'h0, 32'hCAFE_F00D, 2, 4'b1011, 4'b0100, 4,
                32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b0, 32'h8000_0000, 32'h0, 32'h0, 0, 4'b0000, 4'b0000, 1, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 32'hD000_000C, 32'h0, 32'h0BAD_BEEF, 1, 4'b0101, 4'b0010, 3,
                32'h0BAD_BEEF, 1'b0};
    // rdy arrives exactly when a 16-cycle watchdog would expire
    vecs[5] = '{1'b0, 32'h0FFF_FFFC, 32'h0, 32'h7654_3210, 16, 4'b1110, 4'b0001, 18,
                32'h7654_3210, 1'b0};
    vecs[6] = '{1'b1, 32'hD000_0000, 32'h1, 32'h1111_1111, 0, 4'b0000, 4'b0010, 2,
                32'h0, 1'b0};
    vecs[7] = '{1'b1, 32'h1000_0000, 32'h55, 32'h0, 0, 4'b0000, 4'b0000, 1, 32'h0, 1'b1};

    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    slv_rdata = '0;
    slv_rdy   = '0;
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Stray rdy from slot 1 while slot 2 is waiting, then reset mid-transaction
    begin
      logic ok;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'hE000_0000;
      fill_rdata(4'b0100, 32'h2222_2222);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      slv_rdy = 4'b0010;
      ok = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        if (!cpu_busy || slv_sel != 4'b0100 || cpu_ack) ok = 1'b0;
      end
      check("stray rdy ignored", {31'h0, ok}, 32'h1);
      rst = 1'b1;
      #1;
      check_all_zero("mid-op reset");
      @(posedge clk); #1;
      rst     = 1'b0;
      slv_rdy = 4'b0;
      ok = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        if (cpu_ack || cpu_busy) ok = 1'b0;
      end
      check("no ack after reset", {31'h0, ok}, 32'h1);
    end

    // Slot 1 never ready
    begin
      int lat;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'hD000_0000;
      fill_rdata(4'b0010, 32'h3333_3333);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
        @(posedge clk); #1;
        if (cpu_ack) lat = k;
      end
`ifdef BUS_TIMEOUT_EN
      check("timeout latency", lat, 18);
      check("timeout err", {31'h0, cpu_err}, 32'h1);
      check("timeout rdata", cpu_rdata, 32'h0);
      check("timeout sel", {28'h0, slv_sel}, 32'h0);
`else
      check("no timeout ack", lat, 0);
      check("still busy", {31'h0, cpu_busy}, 32'h1);
      check("still selected", {28'h0, slv_sel}, 32'h0000_0002);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
`endif
      @(posedge clk); #1;
    end

    // Back-to-back reads with req held high and slot 0 always ready
    begin
      int          sel_edges[$];
      int          ack_edges[$];
      logic [31:0] ack_data[$];
      logic        prev_sel;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h0000_0020;
      slv_rdy  = 4'b0001;
      fill_rdata(4'b0001, 32'h5555_AAAA);
      prev_sel = 1'b0;
      for (int k = 0; k <= 5; k++) begin
        @(posedge clk); #1;
        if (slv_sel[0] && !prev_sel) sel_edges.push_back(k);
        prev_sel = slv_sel[0];
        if (cpu_ack) begin
          ack_edges.push_back(k);
          ack_data.push_back(cpu_rdata);
          check($sformatf("b2b err @%0d", k), {31'h0, cpu_err}, 32'h0);
        end
        if (k == 2) fill_rdata(4'b0001, 32'h600D_CAFE);
        if (k == 4) cpu_req = 1'b0;
      end
      slv_rdy = 4'b0;
      check("b2b sel rises", sel_edges.size(), 2);
      check("b2b acks", ack_edges.size(), 2);
      if (sel_edges.size() == 2) check("b2b issue interval", sel_edges[1] - sel_edges[0], 3);
      if (ack_edges.size() == 2) begin
        check("b2b ack1 edge", ack_edges[0], 2);
        check("b2b ack2 edge", ack_edges[1], 5);
        check("b2b ack1 data", ack_data[0], 32'h5555_AAAA);
        check("b2b ack2 data", ack_data[1], 32'h600D_CAFE);
      end
      @(posedge clk); #1;
      check("b2b idle", {31'h0, cpu_busy}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
